arbitro_terminais: RTL and testbench
====================================

Name: arbitro_terminais

Overview:
- Sequential arbiter that shares the two output terminals (matrix and LED bank) between the two user inputs (user 0 and user 1).
- Sits between the per-user authentication/function encoding stage and the matrix/LED decoders.
- Replaces the static combinational terminal selector with registered ownership, priority by permission level, round-robin on ties, and minimum/maximum hold times.

Parameters:
- HOLD_MIN, 8, minimum cycles a grant is held once awarded (≥1).
- HOLD_MAX, 64, maximum cycles a grant is held while the other user is waiting (≥HOLD_MIN).
- CNT_W, 7, hold counter width; must represent HOLD_MAX-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- REQ0  in  1  user 0 requests a terminal.
- TERM0  in  1  user 0 target terminal: 0 = matrix, 1 = LEDs.
- PERM0  in  3  user 0 authenticated permission level; 000 = not authenticated.
- CF0  in  3  user 0 encoded function code.
- REQ1, TERM1, PERM1, CF1  in  1/1/3/3  same as above, for user 1.
- GNT_MATRIZ  out  2  matrix owner, one-hot: bit0 = user 0, bit1 = user 1; 00 = free.
- GNT_LEDS  out  2  LED owner, same encoding.
- FMATRIZ  out  3  function code driven to the matrix decoder.
- FLEDS  out  3  function code driven to the LED decoder.
- CONFLITO  out  1  one-cycle pulse when both users contend for the same terminal at an award.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; both terminals LIVRE; counters 0; round-robin pointers = user 0. RST asserted mid-grant drops all grants at that edge.
- Valid request of user x for terminal T: REQx=1, TERMx=T, PERMx≠000. Unauthenticated requests are ignored.
- Each terminal runs an independent FSM with states LIVRE, USO0, USO1. All outputs are registered.
- LIVRE:
  - One valid requester: go to its USO state at the next edge (latency 1).
  - Both valid: higher PERM wins. On equal PERM the round-robin pointer wins, and the pointer then flips to the other user.
  - CONFLITO pulses on the award edge whenever both are valid.
- USOx entry: CNT=0. CNT increments each cycle and saturates at HOLD_MAX-1.
- Release from USOx is evaluated at each edge:
  - (a) Owner's valid request for T is absent and CNT ≥ HOLD_MIN-1 (voluntary release).
  - (b) CNT = HOLD_MAX-1 and the other user has a valid request for T (forced release).
- On release:
  - If the other user is valid, hand off directly to USOother with CNT=0 and no LIVRE gap; a forced handoff does not flip the pointer.
  - Otherwise go to LIVRE.
- Owner request dropped before the minimum hold: grant is retained, but the terminal's F output is 000.
- An owner changing TERM counts as dropping the old terminal and requesting the new one. A user may therefore hold at most one terminal once the old grant expires; holding both briefly is legal.
- F outputs: FMATRIZ/FLEDS = owner's CF registered each cycle while the owner's request is valid. Otherwise 000, including in LIVRE.
- Simultaneous events:
  - Release and a new request on the same edge are resolved in the same edge.
  - The two terminal FSMs never block each other.

Optional Feature:
- Macro: PREEMPCAO_EN.
- Defined: in USOx, if the other user has a valid request for T with PERM strictly greater than the owner's, and CNT ≥ HOLD_MIN-1, hand off immediately. CONFLITO pulses.
- Undefined: no preemption; only release rules (a) and (b) apply.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ0=1 → all outputs 0. Release RST with REQ0=1, TERM0=0, PERM0=011, CF0=101 → after 1 edge GNT_MATRIZ=01, FMATRIZ=101, GNT_LEDS=00.
- Priority: both request LEDs, PERM0=010, PERM1=110, CF1=011 → GNT_LEDS=10, FLEDS=011, CONFLITO=1 for exactly one cycle.
- Tie/round-robin:
  - Both request matrix with PERM=100 → user 0 wins.
  - User 0 drops REQ at CNT=10 → GNT_MATRIZ=10 at the next edge, no 00 cycle.
  - Both drop, then re-request simultaneously → user 1 wins.
- Minimum hold: user 0 granted, drops REQ at CNT=3 → GNT_MATRIZ=01 with FMATRIZ=000 through CNT=7, then 00.
- Starvation/auth: user 1 (PERM=111) holds LEDs continuously while user 0 (PERM=001) waits → handoff exactly at CNT=63. A request with PERM1=000 is never granted.
- PREEMPCAO_EN: user 0 (PERM=010) holds matrix, user 1 requests with PERM=101 at CNT=2 → handoff at CNT=7. Without the macro, handoff only at CNT=63.

Source files
------------

// File: rtl/arbitro_terminais.sv
// arbitro_terminais: shares the matrix and LED terminals between two users.
// Each terminal has its own ownership FSM (LIVRE / USO0 / USO1) with priority by
// permission level, round-robin on ties, and minimum/maximum hold times.
// All outputs are registered.
// Build macro PREEMPCAO_EN: a waiting user with strictly higher permission takes
// the terminal once the owner has served its minimum hold.
module arbitro_terminais #(
  parameter int unsigned HOLD_MIN = 8,
  parameter int unsigned HOLD_MAX = 64,
  parameter int unsigned CNT_W    = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       TERM0,
  input  logic [2:0] PERM0,
  input  logic [2:0] CF0,
  input  logic       REQ1,
  input  logic       TERM1,
  input  logic [2:0] PERM1,
  input  logic [2:0] CF1,
  output logic [1:0] GNT_MATRIZ,
  output logic [1:0] GNT_LEDS,
  output logic [2:0] FMATRIZ,
  output logic [2:0] FLEDS,
  output logic       CONFLITO
);

  typedef enum logic [1:0] {
    StLivre = 2'd0,
    StUso0  = 2'd1,
    StUso1  = 2'd2
  } estado_t;

  localparam logic [CNT_W-1:0] MinLast = CNT_W'(HOLD_MIN - 1);
  localparam logic [CNT_W-1:0] MaxLast = CNT_W'(HOLD_MAX - 1);

  // Terminal 0 = matrix, terminal 1 = LEDs; both use identical logic.
  for (genvar g = 0; g < 2; g++) begin : g_term
    localparam logic TermId = 1'(g);

    estado_t          st_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rr_q;   // round-robin pointer: 0 = user 0 wins next tie
    logic [1:0]       gnt_q;
    logic [2:0]       f_q;
    logic             conf_q;

    logic       v0, v1;
    logic       own1, v_own, v_oth;
    logic [2:0] cf_own;
    logic       win1, pre_c, rel;

    // Request qualification, tie-break winner and release conditions.
    always_comb begin
      v0     = REQ0 && (TERM0 == TermId) && (PERM0 != 3'b000);
      v1     = REQ1 && (TERM1 == TermId) && (PERM1 != 3'b000);
      own1   = (st_q == StUso1);
      v_own  = own1 ? v1 : v0;
      v_oth  = own1 ? v0 : v1;
      cf_own = own1 ? CF1 : CF0;
      win1   = v1 && (!v0 || (PERM1 > PERM0) || ((PERM1 == PERM0) && rr_q));
`ifdef PREEMPCAO_EN
      pre_c  = v_oth && (own1 ? (PERM0 > PERM1) : (PERM1 > PERM0)) && (cnt_q >= MinLast);
`else
      pre_c  = 1'b0;
`endif
      rel    = (!v_own && (cnt_q >= MinLast)) || (v_oth && (cnt_q == MaxLast)) || pre_c;
    end

    // Ownership FSM with registered grant, function code and conflict pulse.
    always_ff @(posedge CLK) begin
      if (RST) begin
        st_q   <= StLivre;
        cnt_q  <= '0;
        rr_q   <= 1'b0;
        gnt_q  <= 2'b00;
        f_q    <= 3'b000;
        conf_q <= 1'b0;
      end else begin
        conf_q <= 1'b0;
        case (st_q)
          StLivre: begin
            cnt_q <= '0;
            if (v0 || v1) begin
              st_q   <= win1 ? StUso1 : StUso0;
              gnt_q  <= win1 ? 2'b10 : 2'b01;
              f_q    <= win1 ? CF1 : CF0;
              conf_q <= v0 && v1;
              // Only a true tie consumes the round-robin turn.
              if (v0 && v1 && (PERM0 == PERM1)) begin
                rr_q <= ~rr_q;
              end
            end else begin
              gnt_q <= 2'b00;
              f_q   <= 3'b000;
            end
          end
          StUso0, StUso1: begin
            if (rel && v_oth) begin
              // Direct handoff, no free cycle; the pointer is left alone.
              st_q   <= own1 ? StUso0 : StUso1;
              gnt_q  <= own1 ? 2'b01 : 2'b10;
              f_q    <= own1 ? CF0 : CF1;
              cnt_q  <= '0;
              conf_q <= v_own;
            end else if (rel) begin
              st_q  <= StLivre;
              gnt_q <= 2'b00;
              f_q   <= 3'b000;
              cnt_q <= '0;
            end else begin
              if (cnt_q != MaxLast) begin
                cnt_q <= cnt_q + 1'b1;
              end
              // Grant retained during minimum hold, but code blanked if request dropped.
              f_q <= v_own ? cf_own : 3'b000;
            end
          end
          default: begin
            st_q  <= StLivre;
            gnt_q <= 2'b00;
            f_q   <= 3'b000;
            cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign GNT_MATRIZ = g_term[0].gnt_q;
  assign GNT_LEDS   = g_term[1].gnt_q;
  assign FMATRIZ    = g_term[0].f_q;
  assign FLEDS      = g_term[1].f_q;
  assign CONFLITO   = g_term[0].conf_q | g_term[1].conf_q;

endmodule

// File: tb/tb_arbitro_terminais.sv
// Self-checking bench for arbitro_terminais: directed scenarios with literal
// expectations plus a randomized run against a cycle-level reference model.
module tb_arbitro_terminais;

  localparam int HOLD_MIN = 8;
  localparam int HOLD_MAX = 64;
`ifdef PREEMPCAO_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, term0, req1, term1;
  logic [2:0] perm0, cf0, perm1, cf1;
  logic [1:0] GNT_MATRIZ, GNT_LEDS;
  logic [2:0] FMATRIZ, FLEDS;
  logic       CONFLITO;

  int n_pass  = 0;
  int n_total = 0;

  arbitro_terminais #(
    .HOLD_MIN(HOLD_MIN),
    .HOLD_MAX(HOLD_MAX),
    .CNT_W   (7)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ0      (req0),
    .TERM0     (term0),
    .PERM0     (perm0),
    .CF0       (cf0),
    .REQ1      (req1),
    .TERM1     (term1),
    .PERM1     (perm1),
    .CF1       (cf1),
    .GNT_MATRIZ(GNT_MATRIZ),
    .GNT_LEDS  (GNT_LEDS),
    .FMATRIZ   (FMATRIZ),
    .FLEDS     (FLEDS),
    .CONFLITO  (CONFLITO)
  );

  always #5 clk = ~clk;

  // Reference model: owner per terminal (-1 = free), cycles since award, tie pointer.
  int         m_own[2];
  int         m_age[2];
  int         m_ptr[2];
  logic [1:0] e_gnt[2];
  logic [2:0] e_f[2];
  logic       e_conf;

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      m_own[t] = -1;
      m_age[t] = 0;
      m_ptr[t] = 0;
      e_gnt[t] = 2'b00;
      e_f[t]   = 3'b000;
    end
    e_conf = 1'b0;
  endtask

  // Predicts the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    int pm[2];
    int cf[2];
    bit v[2][2];
    pm[0] = int'(perm0);
    pm[1] = int'(perm1);
    cf[0] = int'(cf0);
    cf[1] = int'(cf1);
    for (int t = 0; t < 2; t++) begin
      v[0][t] = req0 && (int'(term0) == t) && (pm[0] != 0);
      v[1][t] = req1 && (int'(term1) == t) && (pm[1] != 0);
    end
    e_conf = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    for (int t = 0; t < 2; t++) begin
      if (m_own[t] < 0) begin
        if (v[0][t] && v[1][t]) begin
          e_conf = 1'b1;
          if (pm[0] != pm[1]) begin
            m_own[t] = (pm[1] > pm[0]) ? 1 : 0;
          end else begin
            m_own[t] = m_ptr[t];
            m_ptr[t] = 1 - m_ptr[t];
          end
          m_age[t] = 0;
        end else if (v[0][t] || v[1][t]) begin
          m_own[t] = v[1][t] ? 1 : 0;
          m_age[t] = 0;
        end
      end else begin
        int o = m_own[t];
        int x = 1 - m_own[t];
        bit leave;
        leave = (!v[o][t] && m_age[t] >= HOLD_MIN - 1)
             || (v[x][t] && m_age[t] == HOLD_MAX - 1)
             || (PRE && v[x][t] && pm[x] > pm[o] && m_age[t] >= HOLD_MIN - 1);
        if (leave) begin
          if (v[x][t]) begin
            m_own[t] = x;
            m_age[t] = 0;
            if (v[o][t]) e_conf = 1'b1;
          end else begin
            m_own[t] = -1;
          end
        end else if (m_age[t] < HOLD_MAX - 1) begin
          m_age[t]++;
        end
      end
      e_gnt[t] = (m_own[t] < 0) ? 2'b00 : ((m_own[t] == 0) ? 2'b01 : 2'b10);
      e_f[t]   = (m_own[t] >= 0 && v[m_own[t]][t]) ? 3'(cf[m_own[t]]) : 3'b000;
    end
  endtask

  // One clock: model follows the same inputs, outputs sampled 1 unit after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; term0 = 1'b0; perm0 = 3'b000; cf0 = 3'b000;
    req1 = 1'b0; term1 = 1'b0; perm1 = 3'b000; cf1 = 3'b000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1; term0 = 1'b0; perm0 = 3'b011; cf0 = 3'b101;
    step();
    step();
    n_total++;
    if ({GNT_MATRIZ, GNT_LEDS, FMATRIZ, FLEDS, CONFLITO} !== 11'd0)
      $display("FAIL reset_outputs: got %b want 0", {GNT_MATRIZ, GNT_LEDS, FMATRIZ, FLEDS, CONFLITO});
    else n_pass++;
    rst = 1'b0;
    step();
    n_total++;
    if (GNT_MATRIZ !== 2'b01) $display("FAIL first_grant: got %b want 01", GNT_MATRIZ);
    else n_pass++;
    n_total++;
    if (FMATRIZ !== 3'b101) $display("FAIL first_fmatriz: got %b want 101", FMATRIZ);
    else n_pass++;
    n_total++;
    if (GNT_LEDS !== 2'b00) $display("FAIL first_leds_free: got %b want 00", GNT_LEDS);
    else n_pass++;
    // Reset in the middle of a grant drops it at that edge.
    rst = 1'b1;
    step();
    n_total++;
    if ({GNT_MATRIZ, FMATRIZ} !== 5'd0)
      $display("FAIL reset_mid_grant: got %b want 0", {GNT_MATRIZ, FMATRIZ});
    else n_pass++;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_priority();
    do_reset();
    req0 = 1'b1; term0 = 1'b1; perm0 = 3'b010; cf0 = 3'b111;
    req1 = 1'b1; term1 = 1'b1; perm1 = 3'b110; cf1 = 3'b011;
    step();
    n_total++;
    if (GNT_LEDS !== 2'b10) $display("FAIL prio_gnt: got %b want 10", GNT_LEDS);
    else n_pass++;
    n_total++;
    if (FLEDS !== 3'b011) $display("FAIL prio_fleds: got %b want 011", FLEDS);
    else n_pass++;
    n_total++;
    if (CONFLITO !== 1'b1) $display("FAIL prio_conflito_on: got %b want 1", CONFLITO);
    else n_pass++;
    step();
    n_total++;
    if (CONFLITO !== 1'b0) $display("FAIL prio_conflito_off: got %b want 0", CONFLITO);
    else n_pass++;
    n_total++;
    if (GNT_LEDS !== 2'b10) $display("FAIL prio_hold: got %b want 10", GNT_LEDS);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    req0 = 1'b1; term0 = 1'b0; perm0 = 3'b100; cf0 = 3'b001;
    req1 = 1'b1; term1 = 1'b0; perm1 = 3'b100; cf1 = 3'b010;
    step();
    n_total++;
    if (GNT_MATRIZ !== 2'b01) $display("FAIL rr_first_tie: got %b want 01", GNT_MATRIZ);
    else n_pass++;
    for (int i = 0; i < 10; i++) step();
    req0 = 1'b0;
    step();
    n_total++;
    if ({GNT_MATRIZ, FMATRIZ} !== 5'b10_010)
      $display("FAIL rr_handoff: got %b want 10010", {GNT_MATRIZ, FMATRIZ});
    else n_pass++;
    req1 = 1'b0;
    for (int i = 0; i < HOLD_MIN - 1; i++) step();
    n_total++;
    if (GNT_MATRIZ !== 2'b10) $display("FAIL rr_min_hold: got %b want 10", GNT_MATRIZ);
    else n_pass++;
    step();
    n_total++;
    if (GNT_MATRIZ !== 2'b00) $display("FAIL rr_release: got %b want 00", GNT_MATRIZ);
    else n_pass++;
    req0 = 1'b1;
    req1 = 1'b1;
    step();
    n_total++;
    if ({GNT_MATRIZ, CONFLITO} !== 3'b10_1)
      $display("FAIL rr_second_tie: got %b want 101", {GNT_MATRIZ, CONFLITO});
    else n_pass++;
  endtask

  task automatic test_min_hold();
    do_reset();
    req0 = 1'b1; term0 = 1'b0; perm0 = 3'b011; cf0 = 3'b110;
    step();
    for (int i = 0; i < 3; i++) step();
    req0 = 1'b0;
    for (int c = 4; c <= HOLD_MIN - 1; c++) begin
      step();
      n_total++;
      if ({GNT_MATRIZ, FMATRIZ} !== 5'b01_000)
        $display("FAIL min_hold_cnt%0d: got %b want 01000", c, {GNT_MATRIZ, FMATRIZ});
      else n_pass++;
    end
    step();
    n_total++;
    if (GNT_MATRIZ !== 2'b00) $display("FAIL min_hold_release: got %b want 00", GNT_MATRIZ);
    else n_pass++;
  endtask

  task automatic test_starvation();
    bit held = 1'b1;
    do_reset();
    req1 = 1'b1; term1 = 1'b1; perm1 = 3'b111; cf1 = 3'b110;
    step();
    req0 = 1'b1; term0 = 1'b1; perm0 = 3'b001; cf0 = 3'b100;
    for (int i = 0; i < HOLD_MAX - 1; i++) begin
      step();
      if (GNT_LEDS !== 2'b10) held = 1'b0;
    end
    n_total++;
    if (held !== 1'b1) $display("FAIL starve_hold: got early handoff want held to cnt 63");
    else n_pass++;
    step();
    n_total++;
    if ({GNT_LEDS, FLEDS} !== 5'b01_100)
      $display("FAIL starve_handoff: got %b want 01100", {GNT_LEDS, FLEDS});
    else n_pass++;
  endtask

  task automatic test_auth();
    bit never = 1'b1;
    do_reset();
    req1 = 1'b1; term1 = 1'b0; perm1 = 3'b000; cf1 = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      if (GNT_MATRIZ !== 2'b00 || FMATRIZ !== 3'b000) never = 1'b0;
    end
    n_total++;
    if (never !== 1'b1) $display("FAIL auth_unauth: got grant want none");
    else n_pass++;
  endtask

  task automatic test_preempt();
    int found = 0;
    int want;
    do_reset();
    req0 = 1'b1; term0 = 1'b0; perm0 = 3'b010; cf0 = 3'b011;
    step();
    step();
    step();
    req1 = 1'b1; term1 = 1'b0; perm1 = 3'b101; cf1 = 3'b101;
    want = PRE ? (HOLD_MIN - 1 - 2 + 1) : (HOLD_MAX - 1 - 2 + 1);
    for (int k = 1; k <= 100; k++) begin
      step();
      if (GNT_MATRIZ === 2'b10) begin
        found = k;
        break;
      end
    end
    n_total++;
    if (found != want) $display("FAIL preempt_handoff_step: got %0d want %0d", found, want);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0 = 1'b1; term0 = 1'b0; perm0 = 3'b011; cf0 = 3'b001;
    req1 = 1'b1; term1 = 1'b1; perm1 = 3'b011; cf1 = 3'b010;
    step();
    n_total++;
    if ({GNT_MATRIZ, GNT_LEDS, FMATRIZ, FLEDS, CONFLITO} !== 11'b01_10_001_010_0)
      $display("FAIL independent_terms: got %b want 01100010100",
               {GNT_MATRIZ, GNT_LEDS, FMATRIZ, FLEDS, CONFLITO});
    else n_pass++;
  endtask

  function automatic logic [2:0] rand_perm();
    case ($urandom_range(0, 4))
      0:       return 3'b000;
      1, 2:    return 3'b010;
      3:       return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  task automatic test_random();
    int churn;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      churn = ((i / 400) % 2 == 1) ? 100 : 6;
      if ($urandom_range(1, churn) == 1) begin
        req0 = ($urandom_range(0, 3) != 0); term0 = 1'($urandom_range(0, 1));
        perm0 = rand_perm();
      end
      if ($urandom_range(1, churn) == 1) begin
        req1 = ($urandom_range(0, 3) != 0); term1 = 1'($urandom_range(0, 1));
        perm1 = rand_perm();
      end
      if ($urandom_range(0, 1) == 1) cf0 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) cf1 = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 499) == 0);
      step();
      n_total++;
      if ({GNT_MATRIZ, GNT_LEDS, FMATRIZ, FLEDS, CONFLITO}
          !== {e_gnt[0], e_gnt[1], e_f[0], e_f[1], e_conf})
        $display("FAIL random_cycle%0d: got %b want %b", i,
                 {GNT_MATRIZ, GNT_LEDS, FMATRIZ, FLEDS, CONFLITO},
                 {e_gnt[0], e_gnt[1], e_f[0], e_f[1], e_conf});
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_priority();
    test_round_robin();
    test_min_hold();
    test_starvation();
    test_auth();
    test_preempt();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
